// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : Receive byte buffer placed directly after the UART receiver.
//               Captures each byte on the receiver's single-cycle write strobe
//               into a circular buffer. The buffer presents first-word-fall-
//               through read data, registered occupancy and full/empty flags,
//               and a sticky overrun flag that records dropped bytes.
//
// Ports       : clk            system clock, rising edge
//               rst_n          asynchronous active-low reset
//               i_wr           write strobe (one-cycle pulse from receiver)
//               i_data         received byte, valid with i_wr
//               i_rd           pop request from consumer
//               o_data         head-of-queue byte, 0 when empty
//               o_valid        o_data holds a byte (== ~o_empty)
//               o_empty        occupancy is zero
//               o_full         occupancy is DEPTH
//               o_count        occupancy, 0..DEPTH
//               o_overrun      sticky: a write was dropped while full
//               i_clr_overrun  clears o_overrun (a same-cycle set wins)
//               o_irq          (only with UART_RX_FIFO_IRQ_EN) registered
//                              (count >= THRESH) | overrun
//
// Options     : define UART_RX_FIFO_IRQ_EN to add the o_irq output.
//
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int THRESH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_rd,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_empty,
    output logic              o_full,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overrun,
    input  logic              i_clr_overrun
`ifdef UART_RX_FIFO_IRQ_EN
    ,
    output logic              o_irq
`endif
);

    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

    // Storage (not reset; contents are don't-care until written)
    logic [DATA_W-1:0] r_mem [DEPTH];

    // Pointers carry one extra wrap bit above the storage index
    logic [ADDR_W:0] r_wr_ptr;
    logic [ADDR_W:0] r_rd_ptr;
    logic [ADDR_W:0] r_count;
    logic            r_empty;
    logic            r_full;
    logic            r_overrun;

    logic            w_rd_acc;
    logic            w_wr_acc;
    logic            w_drop;
    logic [ADDR_W:0] w_wr_ptr_nxt;
    logic [ADDR_W:0] w_rd_ptr_nxt;
    logic [ADDR_W:0] w_count_nxt;
    logic            w_overrun_nxt;

    // A pop is honoured only when a byte is present. A write is honoured
    // when there is room, or when a same-cycle pop frees the head slot.
    assign w_rd_acc = i_rd & ~r_empty;
    assign w_wr_acc = i_wr & (~r_full | w_rd_acc);
    assign w_drop   = i_wr & r_full & ~w_rd_acc;

    assign w_wr_ptr_nxt = r_wr_ptr + {{ADDR_W{1'b0}}, w_wr_acc};
    assign w_rd_ptr_nxt = r_rd_ptr + {{ADDR_W{1'b0}}, w_rd_acc};

    // Modular pointer difference is the occupancy, including the wrap bit
    assign w_count_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;

    // Set takes priority over clear
    assign w_overrun_nxt = w_drop | (r_overrun & ~i_clr_overrun);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_empty   <= 1'b1;
            r_full    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_wr_ptr  <= w_wr_ptr_nxt;
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_count   <= w_count_nxt;
            r_empty   <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
            r_full    <= (w_wr_ptr_nxt[ADDR_W-1:0] == w_rd_ptr_nxt[ADDR_W-1:0]) &&
                         (w_wr_ptr_nxt[ADDR_W] != w_rd_ptr_nxt[ADDR_W]);
            r_overrun <= w_overrun_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_data;
        end
    end

    // Fall-through head: gated by the registered empty flag so that an
    // asynchronous reset forces o_data to zero without a clock edge.
    assign o_data    = r_empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign o_valid   = ~r_empty;
    assign o_empty   = r_empty;
    assign o_full    = r_full;
    assign o_count   = r_count;
    assign o_overrun = r_overrun;

`ifdef UART_RX_FIFO_IRQ_EN
    localparam logic [ADDR_W:0] c_thresh = (ADDR_W+1)'(THRESH);

    logic r_irq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (w_count_nxt >= c_thresh) | w_overrun_nxt;
        end
    end

    assign o_irq = r_irq;
`endif

    // c_depth documents the full occupancy value; referenced to keep the
    // relationship between DEPTH and ADDR_W visible in one place.
    logic w_unused_depth;
    assign w_unused_depth = (c_depth == '0);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Directed self-checking bench for uart_rx_fifo. Expected
//               values are hand-computed constants. Define
//               UART_RX_FIFO_IRQ_EN to also exercise o_irq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst_n;
    logic       i_wr;
    logic [7:0] i_data;
    logic       i_rd;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_empty;
    logic       o_full;
    logic [4:0] o_count;
    logic       o_overrun;
    logic       i_clr_overrun;
`ifdef UART_RX_FIFO_IRQ_EN
    logic       o_irq;
`endif

    int n_cmp;
    int n_err;

    uart_rx_fifo #(
        .DATA_W (8),
        .DEPTH  (16),
        .ADDR_W (4),
        .THRESH (8)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_wr          (i_wr),
        .i_data        (i_data),
        .i_rd          (i_rd),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .o_empty       (o_empty),
        .o_full        (o_full),
        .o_count       (o_count),
        .o_overrun     (o_overrun),
        .i_clr_overrun (i_clr_overrun)
`ifdef UART_RX_FIFO_IRQ_EN
        ,
        .o_irq         (o_irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance past one rising edge; inputs change and outputs are sampled
    // 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        i_wr   = 1'b1;
        i_data = d;
        tick();
        i_wr   = 1'b0;
    endtask

    task automatic pop();
        i_rd = 1'b1;
        tick();
        i_rd = 1'b0;
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst_n         = 1'b0;
        i_wr          = 1'b0;
        i_data        = 8'h00;
        i_rd          = 1'b0;
        i_clr_overrun = 1'b0;

        #12;
        check("rst_empty",   32'(o_empty),   32'd1);
        check("rst_full",    32'(o_full),    32'd0);
        check("rst_count",   32'(o_count),   32'd0);
        check("rst_valid",   32'(o_valid),   32'd0);
        check("rst_overrun", 32'(o_overrun), 32'd0);
        check("rst_data",    32'(o_data),    32'd0);
`ifdef UART_RX_FIFO_IRQ_EN
        check("rst_irq",     32'(o_irq),     32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Single byte
        push(8'h5A);
        check("single_valid", 32'(o_valid), 32'd1);
        check("single_data",  32'(o_data),  32'h5A);
        check("single_count", 32'(o_count), 32'd1);
        pop();
        check("single_empty", 32'(o_empty), 32'd1);
        check("single_count0", 32'(o_count), 32'd0);
        check("single_data0", 32'(o_data),  32'h00);

        // Pop while empty is ignored
        pop();
        check("underflow_count", 32'(o_count), 32'd0);
        check("underflow_empty", 32'(o_empty), 32'd1);

        // Fill and overrun
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
        end
        check("fill_full",  32'(o_full),  32'd1);
        check("fill_count", 32'(o_count), 32'd16);
        check("fill_ovr0",  32'(o_overrun), 32'd0);
        push(8'hFF);
        check("ovr_set",   32'(o_overrun), 32'd1);
        check("ovr_count", 32'(o_count),   32'd16);
        check("ovr_head",  32'(o_data),    32'h00);

        // Overrun and clear in the same cycle: set wins
        i_clr_overrun = 1'b1;
        push(8'hEE);
        check("ovr_setwins", 32'(o_overrun), 32'd1);
        tick();
        i_clr_overrun = 1'b0;
        check("ovr_clr", 32'(o_overrun), 32'd0);

        // Full with simultaneous read and write
        i_wr   = 1'b1;
        i_data = 8'hAA;
        i_rd   = 1'b1;
        tick();
        i_wr = 1'b0;
        i_rd = 1'b0;
        check("fullrw_count", 32'(o_count),   32'd16);
        check("fullrw_ovr",   32'(o_overrun), 32'd0);
        check("fullrw_full",  32'(o_full),    32'd1);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("drain_%0d", i), 32'(o_data), 32'(i));
            pop();
        end
        check("drain_last", 32'(o_data), 32'hAA);
        pop();
        check("drain_empty", 32'(o_empty), 32'd1);
        check("drain_count", 32'(o_count), 32'd0);

        // Empty with simultaneous read and write
        i_wr   = 1'b1;
        i_data = 8'h3C;
        i_rd   = 1'b1;
        tick();
        i_wr = 1'b0;
        i_rd = 1'b0;
        check("emptyrw_count", 32'(o_count), 32'd1);
        check("emptyrw_data",  32'(o_data),  32'h3C);
        check("emptyrw_valid", 32'(o_valid), 32'd1);
        pop();
        check("emptyrw_drain", 32'(o_empty), 32'd1);

`ifdef UART_RX_FIFO_IRQ_EN
        // IRQ threshold at 8
        for (int i = 0; i < 7; i++) begin
            push(8'(8'h40 + i));
        end
        check("irq_7", 32'(o_irq), 32'd0);
        push(8'h47);
        check("irq_8", 32'(o_irq), 32'd1);
        pop();
        check("irq_pop", 32'(o_irq), 32'd0);
        for (int i = 0; i < 7; i++) begin
            pop();
        end
        check("irq_drain", 32'(o_empty), 32'd1);
`endif

        // Reset mid-operation
        push(8'hB5);
        push(8'h63);
        check("mid_head", 32'(o_data), 32'hB5);
        for (int i = 0; i < 14; i++) begin
            push(8'(i));
        end
        push(8'h99);
        check("mid_ovr", 32'(o_overrun), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_empty", 32'(o_empty),   32'd1);
        check("mid_count", 32'(o_count),   32'd0);
        check("mid_ovr0",  32'(o_overrun), 32'd0);
        check("mid_data",  32'(o_data),    32'd0);
        check("mid_full",  32'(o_full),    32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        push(8'h11);
        check("post_rst_data", 32'(o_data), 32'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
